packet_tx_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter merging up to 8 AXI4-Stream byte-packet

---
 rtl/packet_tx_arbiter_if.sv | 39 +++
 rtl/packet_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_packet_tx_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_tx_arbiter_if.sv
// Byte-packet source bundle and merged tx_packet stream of the arbiter.
// slave is the arbiter's view, master the view of sources and sink.
interface packet_tx_arbiter_if #(
  parameter int NUM_SOURCES = 4
);
  logic [NUM_SOURCES-1:0]   s_tvalid;
  logic [NUM_SOURCES-1:0]   s_tready;
  logic [8*NUM_SOURCES-1:0] s_tdata;
  logic [NUM_SOURCES-1:0]   s_tlast;
  logic                     tx_packet_tvalid;
  logic                     tx_packet_tready;
  logic [7:0]               tx_packet_tdata;
  logic                     tx_packet_tlast;
  logic [2:0]               tx_packet_tid;

  modport slave (
    input  s_tvalid,
    input  s_tdata,
    input  s_tlast,
    input  tx_packet_tready,
    output s_tready,
    output tx_packet_tvalid,
    output tx_packet_tdata,
    output tx_packet_tlast,
    output tx_packet_tid
  );

  modport master (
    output s_tvalid,
    output s_tdata,
    output s_tlast,
    output tx_packet_tready,
    input  s_tready,
    input  tx_packet_tvalid,
    input  tx_packet_tdata,
    input  tx_packet_tlast,
    input  tx_packet_tid
  );
endinterface

// File: rtl/packet_tx_arbiter.sv
// Packet-granular round-robin merge of up to 8 byte-packet sources
// into one tx_packet stream tagged with the source index.
module packet_tx_arbiter #(
  parameter int NUM_SOURCES = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  packet_tx_arbiter_if.slave   bus,
  output logic                 busy
);
  localparam int N = NUM_SOURCES;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] grant_q, grant_d;
  logic       vld_q, vld_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic [2:0] tid_q, tid_d;

  logic [7:0]  vld_x;
  logic [7:0]  last_x;
  logic [63:0] data_x;
  logic [2:0]  pick;
  logic        found;
  logic        room;
  logic        beat;
  logic [N-1:0] rdy;

  // Widen to 8 lanes so a 3-bit index addresses every source exactly
  assign vld_x  = 8'(bus.s_tvalid);
  assign last_x = 8'(bus.s_tlast);
  assign data_x = 64'(bus.s_tdata);

  always_comb begin
    logic [3:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(N)) idx = idx - 4'(N);
      if (!found && vld_x[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  assign room = ~vld_q | bus.tx_packet_tready;
  assign beat = (state_q == LOCKED) & vld_x[grant_q] & room;

  always_comb begin
    rdy = '0;
    for (int i = 0; i < N; i++) begin
      if (state_q == LOCKED && grant_q == 3'(i)) rdy[i] = room;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (beat && last_x[grant_q]) begin
          state_d = IDLE;
          ptr_d   = (grant_q == 3'(N - 1)) ? 3'd0 : grant_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slice drains on its own, loads win over a same-cycle drain
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    tid_d  = tid_q;
    if (vld_q && bus.tx_packet_tready) vld_d = 1'b0;
    if (beat) begin
      vld_d  = 1'b1;
      data_d = data_x[{grant_q, 3'b000} +: 8];
      last_d = last_x[grant_q];
      tid_d  = grant_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      tid_q   <= tid_d;
    end
  end

  assign bus.s_tready         = rdy;
  assign bus.tx_packet_tvalid = vld_q;
  assign bus.tx_packet_tdata  = data_q;
  assign bus.tx_packet_tlast  = last_q;
  assign bus.tx_packet_tid    = tid_q;
  assign busy                 = (state_q == LOCKED);
endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Randomised bench for packet_tx_arbiter with a queue-based
// reference of sent packets, round-robin order and fairness.
module tb_packet_tx_arbiter;
  localparam int NS = 4;

  typedef struct {
    int         tid;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } obs_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic busy;

  always #5 aclk = ~aclk;

  packet_tx_arbiter_if #(.NUM_SOURCES(NS)) bus();

  packet_tx_arbiter #(.NUM_SOURCES(NS)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .busy    (busy)
  );

  obs_t       log_q[$];
  logic [8:0] src_q[NS][$];
  logic [8:0] exp_q[NS][$];
  logic [NS-1:0] stall;
  logic [NS-1:0] held;
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  vpct = 100;
  int  rpct = 100;
  bit  rmode = 1'b0;
  logic rval = 1'b1;

  function automatic int rr_pick(input int p, input logic [NS-1:0] m);
    for (int k = 0; k < NS; k++)
      if (m[(p + k) % NS]) return (p + k) % NS;
    return -1;
  endfunction

  task automatic push_pkt(input int s, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      src_q[s].push_back({k == len - 1, base + 8'(k)});
      exp_q[s].push_back({k == len - 1, base + 8'(k)});
    end
  endtask

  task automatic cycle();
    logic [NS-1:0] acc;
    logic oacc;
    obs_t o;
    @(negedge aclk);
    acc  = bus.s_tvalid & bus.s_tready;
    held = bus.s_tvalid & ~bus.s_tready;
    oacc = bus.tx_packet_tvalid & bus.tx_packet_tready;
    o.tid  = int'(bus.tx_packet_tid);
    o.data = bus.tx_packet_tdata;
    o.last = bus.tx_packet_tlast;
    @(posedge aclk);
    #1;
    cyc++;
    o.cyc = cyc;
    if (oacc === 1'b1) log_q.push_back(o);
    for (int i = 0; i < NS; i++) begin
      logic v;
      logic [8:0] h;
      if (acc[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
      h = (src_q[i].size() > 0) ? src_q[i][0] : 9'h0;
      v = 1'b0;
      if (held[i] === 1'b1 && src_q[i].size() > 0) v = 1'b1;
      else if (src_q[i].size() > 0 && !stall[i] && int'($urandom_range(99)) < vpct) v = 1'b1;
      bus.s_tvalid[i] = v;
      bus.s_tlast[i] = h[8];
      bus.s_tdata[8*i +: 8] = h[7:0];
    end
    bus.tx_packet_tready = rmode ? (int'($urandom_range(99)) < rpct) : rval;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    log_q.delete();
    stall = '0;
    held = '0;
    bus.s_tvalid = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    cycle();
    aresetn = 1'b1;
    clear_all();
  endtask

  task automatic run_log(input int n, input int lim, output bit ok);
    for (int t = 0; t < lim && log_q.size() < n; t++) cycle();
    ok = (log_q.size() >= n);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cycle();
    cycle();
    n_vec++;
    if (bus.s_tready !== '0) begin
      n_err++; $display("FAIL reset_s_tready got %b want 0", bus.s_tready);
    end
    n_vec++;
    if (bus.tx_packet_tvalid !== 1'b0 || bus.tx_packet_tlast !== 1'b0) begin
      n_err++; $display("FAIL reset_tvalid_tlast got %b%b want 00",
        bus.tx_packet_tvalid, bus.tx_packet_tlast);
    end
    n_vec++;
    if (bus.tx_packet_tdata !== 8'h0 || bus.tx_packet_tid !== 3'h0) begin
      n_err++; $display("FAIL reset_tdata_tid got %h/%h want 0/0",
        bus.tx_packet_tdata, bus.tx_packet_tid);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b want 0", busy);
    end
    aresetn = 1'b1;
    cycle();
    cycle();
    n_vec++;
    if (busy !== 1'b0 || bus.tx_packet_tvalid !== 1'b0) begin
      n_err++; $display("FAIL idle_no_req got busy=%b tvalid=%b want 0/0",
        busy, bus.tx_packet_tvalid);
    end
  endtask

  task automatic test_single_source();
    int c0;
    bit ok;
    log_q.delete();
    rmode = 1'b0;
    rval = 1'b1;
    push_pkt(1, 3, 8'hA1);
    c0 = cyc;
    run_log(3, 30, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL basic_timeout got %0d beats want 3", log_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (log_q[k].tid != 1 || log_q[k].data !== 8'hA1 + 8'(k) ||
            log_q[k].last !== (k == 2)) begin
          n_err++; $display("FAIL basic_beat%0d got tid=%0d d=%h l=%b want tid=1 d=%h l=%b",
            k, log_q[k].tid, log_q[k].data, log_q[k].last, 8'hA1 + 8'(k), k == 2);
        end
        n_vec++;
        if (log_q[k].cyc != c0 + 4 + k) begin
          n_err++; $display("FAIL basic_timing%0d got cycle %0d want %0d",
            k, log_q[k].cyc - c0, 4 + k);
        end
      end
    end
    for (int i = 0; i < NS; i++) exp_q[i].delete();
  endtask

  task automatic check_order(input string nm, input int ptr0, input logic [NS-1:0] m0);
    logic [11:0] ex[$];
    logic [11:0] got;
    logic [NS-1:0] m;
    int p, g, nb;
    bit ok;
    m = m0;
    p = ptr0;
    while (m != '0) begin
      g = rr_pick(p, m);
      m[g] = 1'b0;
      p = (g + 1) % NS;
      while (exp_q[g].size() > 0) begin
        logic [8:0] b;
        b = exp_q[g].pop_front();
        ex.push_back({3'(g), b[7:0], b[8]});
        if (b[8]) break;
      end
    end
    nb = ex.size();
    run_log(nb, 40 * nb, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL %s_timeout got %0d beats want %0d", nm, log_q.size(), nb);
    end else begin
      for (int k = 0; k < nb; k++) begin
        got = {3'(log_q[k].tid), log_q[k].data, log_q[k].last};
        n_vec++;
        if (got !== ex[k]) begin
          n_err++; $display("FAIL %s_beat%0d got tid/data/last %h want %h", nm, k, got, ex[k]);
        end
      end
    end
    log_q.delete();
  endtask

  task automatic test_round_robin();
    do_reset();
    rmode = 1'b0;
    rval = 1'b1;
    push_pkt(0, 2, 8'h01);
    push_pkt(2, 2, 8'h21);
    push_pkt(3, 2, 8'h31);
    check_order("rr", 0, 4'b1101);
    push_pkt(1, 2, 8'h41);
    push_pkt(0, 2, 8'h51);
    check_order("rr_wrap", 0, 4'b0011);
  endtask

  task automatic test_backpressure();
    logic [12:0] snap, now;
    bit ok;
    log_q.delete();
    rmode = 1'b0;
    rval = 1'b1;
    push_pkt(2, 8, 8'hC0);
    run_log(2, 30, ok);
    rval = 1'b0;
    bus.tx_packet_tready = 1'b0;
    snap = {bus.tx_packet_tvalid, bus.tx_packet_tdata, bus.tx_packet_tlast, bus.tx_packet_tid};
    for (int t = 0; t < 5; t++) begin
      cycle();
      now = {bus.tx_packet_tvalid, bus.tx_packet_tdata, bus.tx_packet_tlast, bus.tx_packet_tid};
      n_vec++;
      if (now !== snap || now[12] !== 1'b1) begin
        n_err++; $display("FAIL bp_stable%0d got %h want %h (valid)", t, now, snap);
      end
      n_vec++;
      if (bus.s_tready[2] !== 1'b0) begin
        n_err++; $display("FAIL bp_s_tready%0d got %b want 0", t, bus.s_tready[2]);
      end
    end
    rval = 1'b1;
    run_log(8, 40, ok);
    for (int t = 0; t < 4; t++) cycle();
    n_vec++;
    if (log_q.size() != 8) begin
      n_err++; $display("FAIL bp_count got %0d beats want 8", log_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (log_q[k].tid != 2 || log_q[k].data !== 8'hC0 + 8'(k) ||
            log_q[k].last !== (k == 7)) begin
          n_err++; $display("FAIL bp_beat%0d got tid=%0d d=%h l=%b want tid=2 d=%h l=%b",
            k, log_q[k].tid, log_q[k].data, log_q[k].last, 8'hC0 + 8'(k), k == 7);
        end
      end
    end
    for (int i = 0; i < NS; i++) exp_q[i].delete();
    log_q.delete();
  endtask

  task automatic test_stall();
    do_reset();
    rmode = 1'b0;
    rval = 1'b1;
    push_pkt(0, 4, 8'h70);
    push_pkt(1, 2, 8'h80);
    for (int t = 0; t < 30 && src_q[0].size() > 2; t++) cycle();
    stall[0] = 1'b1;
    bus.s_tvalid[0] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      cycle();
      n_vec++;
      if (bus.s_tready[1] !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL stall%0d got s_tready1=%b busy=%b want 0/1",
          t, bus.s_tready[1], busy);
      end
    end
    stall[0] = 1'b0;
    check_order("stall", 0, 4'b0011);
  endtask

  task automatic test_reset_mid();
    int lasts;
    do_reset();
    rmode = 1'b0;
    rval = 1'b1;
    push_pkt(2, 4, 8'h90);
    for (int t = 0; t < 30 && src_q[2].size() > 3; t++) cycle();
    aresetn = 1'b0;
    cycle();
    aresetn = 1'b1;
    n_vec++;
    if ({bus.tx_packet_tvalid, bus.tx_packet_tlast, bus.tx_packet_tid,
         bus.tx_packet_tdata, bus.s_tready, busy} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs got v=%b l=%b tid=%h d=%h rdy=%b busy=%b want all 0",
        bus.tx_packet_tvalid, bus.tx_packet_tlast, bus.tx_packet_tid,
        bus.tx_packet_tdata, bus.s_tready, busy);
    end
    lasts = 0;
    foreach (log_q[k]) if (log_q[k].last) lasts++;
    clear_all();
    for (int t = 0; t < 4; t++) cycle();
    foreach (log_q[k]) if (log_q[k].last) lasts++;
    n_vec++;
    if (lasts != 0) begin
      n_err++; $display("FAIL rstmid_tlast got %0d tlast beats want 0", lasts);
    end
    log_q.delete();
    push_pkt(3, 2, 8'hB0);
    push_pkt(1, 2, 8'hD0);
    check_order("rstmid", 0, 4'b1010);
  endtask

  task automatic test_random();
    int sent, waitc[NS];
    bit done;
    do_reset();
    rmode = 1'b1;
    rpct = 70;
    vpct = 100;
    sent = 0;
    done = 1'b0;
    for (int i = 0; i < NS; i++) waitc[i] = 0;
    for (int t = 0; t < 60000 && !done; t++) begin
      for (int s = 0; s < NS; s++)
        if (sent < 1000 && src_q[s].size() < 33) begin
          push_pkt(s, int'($urandom_range(32, 1)), 8'($urandom));
          sent++;
        end
      cycle();
      while (log_q.size() > 0) begin
        obs_t e;
        logic [8:0] b;
        e = log_q.pop_front();
        n_vec++;
        if (e.tid >= NS || exp_q[e.tid].size() == 0) begin
          n_err++; $display("FAIL rnd_extra got tid=%0d d=%h want no beat", e.tid, e.data);
          continue;
        end
        b = exp_q[e.tid].pop_front();
        if ({e.last, e.data} !== b) begin
          n_err++; $display("FAIL rnd_data tid=%0d got l=%b d=%h want l=%b d=%h",
            e.tid, e.last, e.data, b[8], b[7:0]);
        end
        waitc[e.tid] = 0;
        if (e.last) begin
          for (int j = 0; j < NS; j++) begin
            if (j == e.tid || src_q[j].size() == 0) continue;
            waitc[j]++;
            n_vec++;
            if (waitc[j] > 3) begin
              n_err++; $display("FAIL rnd_fair src%0d got wait %0d pkts want <=3", j, waitc[j]);
            end
          end
        end
      end
      done = (sent >= 1000);
      for (int s = 0; s < NS; s++) if (exp_q[s].size() > 0) done = 1'b0;
    end
    n_vec++;
    if (!done) begin
      n_err++; $display("FAIL rnd_timeout got %0d pkts queued, undrained want drained", sent);
    end
    rmode = 1'b0;
  endtask

  initial begin
    bus.s_tvalid = '0;
    bus.s_tdata = '0;
    bus.s_tlast = '0;
    bus.tx_packet_tready = 1'b0;
    stall = '0;
    held = '0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
